// File: rtl/nvram_upload.sv
// nvram_upload: serves HPS upload reads of a 1K x 4 CMOS RAM, packing two nibbles per byte.
module nvram_upload #(
    parameter int          NIB_AW  = 10,
    parameter logic [15:0] INDEX   = 16'd4,
    parameter int          TIMEOUT = 255,
    parameter logic [7:0]  FILL    = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [15:0]       ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [NIB_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [3:0]        mem_dout,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    localparam logic [24:0] BYTES = 25'(2 ** (NIB_AW - 1));
    state_t            state_q, state_d;
    logic [7:0]        din_q, din_d, cnt_q, cnt_d, cnt_inc;
    logic [NIB_AW-1:0] addr_q, addr_d;
    logic [3:0]        lo_q, lo_d, nib;
    logic              act_q, act_d, terr_q, terr_d, upl_q;
    logic              accept, expired;
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q && !(ioctl_upload && !upl_q);
        cnt_inc = cnt_q + 8'd1;
        accept  = ioctl_rd && ioctl_upload && ioctl_index == INDEX;
        // a timed-out nibble reads as all ones and advances like an ack
        expired = !mem_ack && cnt_inc == 8'(TIMEOUT);
        nib     = mem_ack ? mem_dout : 4'hF;
        if (state_q == IDLE) begin
            if (accept && ioctl_addr >= BYTES) begin
                din_d = FILL;
            end else if (accept) begin
                state_d = LO;
                addr_d  = {ioctl_addr[NIB_AW-2:0], 1'b0};
                cnt_d   = '0;
            end
        end else if (!ioctl_upload) begin
            state_d = IDLE;
        end else if (mem_ack || expired) begin
            cnt_d  = '0;
            terr_d = terr_d || expired;
            if (state_q == LO) begin
                lo_d      = nib;
                addr_d[0] = 1'b1;
                state_d   = HI;
            end else begin
                din_d   = {nib, lo_q};
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_inc;
        end
        act_d = state_d != IDLE;
    end
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            act_q   <= 1'b0;
            terr_q  <= 1'b0;
            upl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            terr_q  <= terr_d;
            upl_q   <= ioctl_upload;
        end
    end
    assign ioctl_din   = din_q;
    assign ioctl_wait  = act_q;
    assign mem_rd      = act_q;
    assign busy        = act_q;
    assign mem_addr    = addr_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: randomized reads against a cycle-level expectation model of the upload path.
module tb_nvram_upload;
    localparam int TO = 4;
    logic        clk_sys = 1'b0;
    logic        reset_n, ioctl_upload, ioctl_rd, mem_ack;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_index;
    logic [3:0]  mem_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait, mem_rd, busy, timeout_err;
    logic [9:0]  mem_addr;
    logic [3:0]  ram [1024];
    logic [7:0]  exp_din;
    logic [9:0]  exp_addr;
    logic        exp_act, exp_terr, chk_en;
    int          cmp_n = 0, err_n = 0;
    nvram_upload #(.NIB_AW(10), .INDEX(16'd4), .TIMEOUT(TO), .FILL(8'hFF)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
        .mem_dout(mem_dout), .busy(busy), .timeout_err(timeout_err)
    );
    always #5 clk_sys = ~clk_sys;
    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        cmp_n++;
        if (got !== want) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask
    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("ioctl_din", 16'(ioctl_din), 16'(exp_din));
            chk("ioctl_wait", 16'(ioctl_wait), 16'(exp_act));
            chk("mem_rd", 16'(mem_rd), 16'(exp_act));
            chk("busy", 16'(busy), 16'(exp_act));
            chk("timeout_err", 16'(timeout_err), 16'(exp_terr));
            if (exp_act) chk("mem_addr", 16'(mem_addr), 16'(exp_addr));
        end
    end
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask
    task automatic set_upload(input logic v);
        logic prev;
        prev = ioctl_upload;
        ioctl_upload = v;
        step();
        if (v && !prev) exp_terr = 1'b0;
    endtask
    // delay d: ack arrives d cycles after the nibble request; d >= TO never acks in time
    task automatic do_read(input int addr, input logic [15:0] idx, input int d0, input int d1,
                           output int wcnt, output logic [9:0] a0, output logic [9:0] a1);
        logic [3:0] lo, nib;
        int d;
        logic done;
        wcnt = 0;
        a0 = '0;
        a1 = '0;
        lo = '0;
        ioctl_addr = 25'(addr);
        ioctl_index = idx;
        ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        if (!(ioctl_upload && idx == 16'd4)) return;
        if (addr >= 512) begin
            exp_din = 8'hFF;
            return;
        end
        exp_act = 1'b1;
        exp_addr = 10'(addr * 2);
        for (int n = 0; n < 2; n++) begin
            d = (n == 0) ? d0 : d1;
            if (n == 0) a0 = mem_addr; else a1 = mem_addr;
            for (int k = 0; k < TO; k++) begin
                mem_ack = (k == d);
                mem_dout = (k == d) ? ram[exp_addr] : 4'($urandom);
                ioctl_rd = 1'($urandom_range(0, 1));
                wcnt += int'(ioctl_wait);
                step();
                done = (k == d) || (k == TO - 1);
                if (done) begin
                    nib = (k == d) ? ram[exp_addr] : 4'hF;
                    if (k != d) exp_terr = 1'b1;
                    if (n == 0) begin
                        lo = nib;
                        exp_addr = exp_addr + 10'd1;
                    end else begin
                        exp_act = 1'b0;
                        exp_din = {nib, lo};
                    end
                    break;
                end
            end
        end
        mem_ack = 1'b0;
        ioctl_rd = 1'b0;
    endtask
    task automatic do_abort(input int addr, input bit use_reset);
        ioctl_addr = 25'(addr);
        ioctl_index = 16'd4;
        ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        exp_act = 1'b1;
        exp_addr = 10'(addr * 2);
        if (!use_reset) begin
            mem_ack = 1'b1;
            mem_dout = ram[exp_addr];
            step();
            mem_ack = 1'b0;
            exp_addr = exp_addr + 10'd1;
            ioctl_upload = 1'b0;
            step();
            exp_act = 1'b0;
        end else begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            exp_act = 1'b0;
            exp_din = 8'h00;
            exp_terr = 1'b0;
        end
        chk("abort_busy", 16'(busy), 16'd0);
        mem_ack = 1'b1;
        mem_dout = 4'h7;
        step();
        mem_ack = 1'b0;
        chk("late_ack_busy", 16'(busy), 16'd0);
        chk("late_ack_mem_rd", 16'(mem_rd), 16'd0);
        if (!use_reset) set_upload(1'b1);
    endtask
    function automatic int pick_delay();
        int x;
        x = int'($urandom_range(0, 5));
        return (x < 4) ? x : 99;
    endfunction
    initial begin
        int w;
        logic [9:0] a0, a1;
        logic [7:0] held;
        chk_en = 1'b0;
        reset_n = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd = 1'b0;
        ioctl_addr = '0;
        ioctl_index = '0;
        mem_ack = 1'b0;
        mem_dout = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 4'($urandom);
        exp_din = 8'h00;
        exp_act = 1'b0;
        exp_terr = 1'b0;
        exp_addr = '0;
        step();
        step();
        chk("reset_din", 16'(ioctl_din), 16'h00);
        chk("reset_mem_addr", 16'(mem_addr), 16'h000);
        chk("reset_busy", 16'(busy), 16'd0);
        chk_en = 1'b1;
        reset_n = 1'b1;
        set_upload(1'b1);
        ram[0] = 4'h3;
        ram[1] = 4'hA;
        do_read(0, 16'd4, 0, 0, w, a0, a1);
        chk("imm_din", 16'(ioctl_din), 16'hA3);
        chk("imm_wait_cycles", 16'(w), 16'd2);
        chk("imm_addr_lo", 16'(a0), 16'd0);
        chk("imm_addr_hi", 16'(a1), 16'd1);
        ram[1022] = 4'h5;
        ram[1023] = 4'hC;
        do_read(511, 16'd4, 3, 3, w, a0, a1);
        chk("dly_din", 16'(ioctl_din), 16'hC5);
        chk("dly_wait_cycles", 16'(w), 16'd8);
        chk("dly_addr_lo", 16'(a0), 16'd1022);
        chk("dly_addr_hi", 16'(a1), 16'd1023);
        do_read(512, 16'd4, 0, 0, w, a0, a1);
        chk("oor_din", 16'(ioctl_din), 16'hFF);
        chk("oor_wait", 16'(ioctl_wait), 16'd0);
        do_read(5, 16'd4, 99, 99, w, a0, a1);
        chk("to_din", 16'(ioctl_din), 16'hFF);
        chk("to_err", 16'(timeout_err), 16'd1);
        set_upload(1'b0);
        set_upload(1'b1);
        chk("to_err_clear", 16'(timeout_err), 16'd0);
        do_read(0, 16'd4, 1, 0, w, a0, a1);
        held = ioctl_din;
        do_read(1, 16'd0, 0, 0, w, a0, a1);
        chk("wrong_index_din", 16'(ioctl_din), 16'(held));
        set_upload(1'b0);
        do_read(1, 16'd4, 0, 0, w, a0, a1);
        chk("no_upload_din", 16'(ioctl_din), 16'(held));
        set_upload(1'b1);
        do_abort(77, 1'b0);
        chk("abort_hi_din", 16'(ioctl_din), 16'(held));
        do_abort(300, 1'b1);
        chk("abort_rst_din", 16'(ioctl_din), 16'h00);
        set_upload(1'b1);
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                set_upload(1'b0);
                set_upload(1'b1);
            end else begin
                do_read(int'($urandom_range(0, 639)), (r == 1) ? 16'($urandom_range(0, 7)) : 16'd4,
                        pick_delay(), pick_delay(), w, a0, a1);
            end
        end
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Serves HPS upload (save) requests for the game's 1K x 4 CMOS/high-score RAM. This is the read direction of the ioctl path; the write direction is the ROM download path.
- Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_addr → ioctl_din/ioctl_wait) and a read port arbitrated into the game's CMOS RAM.
- Packs two 4-bit nibbles into each uploaded byte and stretches each HPS read with ioctl_wait until both nibbles are fetched.

Parameters:
- NIB_AW, 10, nibble address width of CMOS RAM; byte space = 2^(NIB_AW-1) bytes (512 at default).
- INDEX, 4, ioctl_index value this block responds to.
- TIMEOUT, 255, max cycles to wait for mem_ack per nibble (1..255).
- FILL, 8'hFF, byte returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock (12 MHz core clock).
- reset_n  in  1  synchronous active-low reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte address of the read.
- ioctl_index  in  16  upload target index.
- ioctl_din  out  8  read data to hps_io.
- ioctl_wait  out  1  stall to HPS; high while a fetch is in progress.
- mem_addr  out  NIB_AW  nibble address to the CMOS RAM arbiter.
- mem_rd  out  1  read request; held high until mem_ack or timeout.
- mem_ack  in  1  grant; mem_dout is valid in the same cycle.
- mem_dout  in  4  nibble data.
- busy  out  1  high in any non-IDLE state.
- timeout_err  out  1  sticky flag: at least one nibble timed out this session.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge), all registered: ioctl_din=0, ioctl_wait=0, mem_rd=0, mem_addr=0, busy=0, timeout_err=0, state=IDLE, timeout counter=0. Reset mid-fetch aborts immediately; no ack is consumed.
- Request accept: accepted in IDLE only, when ioctl_rd=1, ioctl_upload=1 and ioctl_index==INDEX. Otherwise the strobe is ignored and ioctl_din holds its value.
- Out-of-range: if ioctl_addr >= 2^(NIB_AW-1), at T+1 ioctl_din=FILL, ioctl_wait stays 0, state stays IDLE.
- In-range, accept at T: at T+1 state=LO, ioctl_wait=1, mem_rd=1, mem_addr={ioctl_addr[NIB_AW-2:0],1'b0}.
- LO: at the edge where mem_rd=1 and mem_ack=1, latch lo=mem_dout. Next cycle: state=HI, mem_addr LSB=1, mem_rd stays 1, timeout counter cleared.
- HI: on ack, latch hi=mem_dout. Next cycle: state=IDLE, ioctl_din={hi,lo}, ioctl_wait=0, mem_rd=0.
- Latency: with immediate ack, ioctl_din is valid and ioctl_wait is low at T+3. Each extra cycle of ack delay adds one cycle.
- Timeout: the counter increments each cycle in LO/HI without ack. When it equals TIMEOUT, the nibble is taken as 4'hF, timeout_err is set, and the FSM advances exactly as if acked.
- Ack after timeout: a late mem_ack while mem_rd=0 is ignored.
- ioctl_upload falls in LO/HI: next cycle return to IDLE, mem_rd=0, ioctl_wait=0, ioctl_din unchanged.
- timeout_err clears on the rising edge of ioctl_upload and on reset.
- ioctl_rd while busy: ignored, no queuing. hps_io must honour ioctl_wait.
- Address wrap: none; the byte address is truncated only after the range check.

Test Plan:
- Immediate ack: RAM nibbles [0]=4'h3, [1]=4'hA; upload index 4, rd addr 0 at T → ioctl_wait high T+1..T+2; at T+3 ioctl_din=8'hA3, ioctl_wait=0; mem_addr sequence 0 then 1.
- Delayed ack (3 cycles each) at addr 511 → mem_addr 1022 then 1023; ioctl_wait high for 8 cycles; ioctl_din={nib1023,nib1022}.
- Out-of-range rd addr 512 → ioctl_din=8'hFF at T+1; ioctl_wait never asserted; mem_rd never asserted.
- No ack, TIMEOUT=4 → ioctl_din=8'hFF, timeout_err=1. Drop then raise ioctl_upload → timeout_err=0.
- Wrong index (0), and rd with ioctl_upload=0 → no response, ioctl_din unchanged.
- ioctl_upload deasserted during HI, and separately reset_n=0 during LO → next cycle mem_rd=0, ioctl_wait=0, busy=0. A late mem_ack causes no state change.
